// File: rtl/sha3_pad_blk.sv
// sha3_pad_blk: packs a SHA3-256 message byte stream into 64-bit Keccak lanes,
// applies SHA3 domain padding over the 136-byte rate and appends the zero
// capacity lanes, emitting 25 lanes per message in perm_blk input order.
`timescale 1ns/1ps
module sha3_pad_blk #(
  parameter int         RATE_LANES = 17,
  parameter int         NUM_LANES  = 25,
  parameter logic [7:0] DSUFFIX    = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        firstin,
  input  logic        lastin,
  input  logic [7:0]  din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic [63:0] dout,
  output logic        err
);

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LANES_END = 5'(NUM_LANES);

  typedef enum logic [2:0] {IDLE, COLLECT, PAD, ZERO, DRAIN} state_t;

  state_t      state, state_nx;
  logic [2:0]  bc, bc_nx;
  logic [4:0]  lc, lc_nx;
  logic [63:0] acc, acc_nx;
  logic        sfx_done, sfx_nx;
  logic        ld;
  logic [63:0] ld_val;
  logic [63:0] pad_lane;
  logic        err_nx;
  logic        accept, out_free;

  assign accept   = pushin && !stopin;
  // Output register can take a new lane when empty or draining this cycle.
  assign out_free = !pushout || !stopout;

  // Padded version of the current lane: kept bytes below bc, suffix at bc
  // (only on the first pad lane), 0x80 folded into the last rate byte.
  always_comb begin
    pad_lane = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < bc)
        pad_lane[8*i +: 8] = acc[8*i +: 8];
      else if (3'(i) == bc && !sfx_done)
        pad_lane[8*i +: 8] = DSUFFIX;
    end
    if (lc == LAST_RATE)
      pad_lane[63:56] = pad_lane[63:56] ^ 8'h80;
  end

  // Next-state, counters, lane load request and input stall.
  always_comb begin
    state_nx = state;
    bc_nx    = bc;
    lc_nx    = lc;
    acc_nx   = acc;
    sfx_nx   = sfx_done;
    ld       = 1'b0;
    ld_val   = 64'h0;
    err_nx   = 1'b0;
    stopin   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (firstin) begin
            acc_nx   = {56'h0, din};
            bc_nx    = 3'd1;
            lc_nx    = 5'd0;
            sfx_nx   = 1'b0;
            state_nx = lastin ? PAD : COLLECT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      COLLECT: begin
        stopin = pushout && stopout;
        if (accept) begin
          err_nx = firstin;
          acc_nx[{bc, 3'b000} +: 8] = din;
          bc_nx = bc + 3'd1;
          if (bc == 3'd7) begin
            ld     = 1'b1;
            ld_val = {din, acc[55:0]};
            lc_nx  = lc + 5'd1;
          end
          // Last rate byte arriving as data means the message overran the block.
          if (lc == LAST_RATE && bc == 3'd7) begin
            err_nx   = 1'b1;
            state_nx = lastin ? IDLE : DRAIN;
          end else if (lastin) begin
            state_nx = PAD;
          end
        end
      end
      PAD: begin
        stopin = 1'b1;
        if (out_free) begin
          ld     = 1'b1;
          ld_val = pad_lane;
          lc_nx  = lc + 5'd1;
          bc_nx  = 3'd0;
          sfx_nx = 1'b1;
          if (lc == LAST_RATE)
            state_nx = ZERO;
        end
      end
      ZERO: begin
        stopin = 1'b1;
        if (lc == LANES_END) begin
          // Wait for the final capacity lane to leave before accepting input.
          if (out_free) begin
            state_nx = IDLE;
            lc_nx    = 5'd0;
          end
        end else if (out_free) begin
          ld    = 1'b1;
          lc_nx = lc + 5'd1;
        end
      end
      DRAIN: begin
        if (accept && lastin)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters, lane accumulator and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bc       <= 3'd0;
      lc       <= 5'd0;
      acc      <= 64'h0;
      sfx_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      bc       <= bc_nx;
      lc       <= lc_nx;
      acc      <= acc_nx;
      sfx_done <= sfx_nx;
      err      <= err_nx;
    end
  end

  // Output lane register; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pushout  <= 1'b0;
      firstout <= 1'b0;
      dout     <= 64'h0;
    end else if (out_free) begin
      pushout  <= ld;
      firstout <= ld && (lc == 5'd0);
      if (ld)
        dout <= ld_val;
    end
  end

endmodule
